parity_frame_rx: RTL

Serial frame receiver with XOR parity check. It deserialises one start bit, DATA_W data bits (LSB first), one parity bit and one stop bit, advancing one bit per `bit_en` strobe. It is the receive-side counterpart to the team's XOR parity generator and serial transmit path, and sits between the serial line and the byte-wide consumer logic.

---
 rtl/parity_frame_pkg.sv | 23 ++
 rtl/parity_frame_rx_if.sv | 25 ++
 rtl/parity_accum.sv | 34 +++
 rtl/parity_frame_rx.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/parity_frame_pkg.sv
// Shared types and constants for the parity-checked serial frame receiver.
// Line levels, FSM encoding and bit-counter sizing live here so tx and rx agree.
package parity_frame_pkg;

  localparam int unsigned StateW       = 2;
  localparam int unsigned DefaultDataW = 8;

  localparam logic IdleLevel  = 1'b1;
  localparam logic StartLevel = 1'b0;

  typedef enum logic [StateW-1:0] {
    StIdle   = 2'd0,
    StData   = 2'd1,
    StParity = 2'd2,
    StStop   = 2'd3
  } state_e;

  // Counter must hold 0..data_w so the last-bit compare never wraps.
  function automatic int unsigned cnt_width(input int unsigned data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/parity_frame_rx_if.sv
// Serial-line and word-output bundle for parity_frame_rx.
// The slave modport is the receiver; master is the line driver / word consumer.
interface parity_frame_rx_if #(
  parameter int unsigned DATA_W = 8
);

  logic              bit_en;
  logic              rx_in;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;

  modport master (
    output bit_en, rx_in,
    input  data, valid, parity_err, frame_err, busy
  );

  modport slave (
    input  bit_en, rx_in,
    output data, valid, parity_err, frame_err, busy
  );

endinterface

// File: rtl/parity_accum.sv
// Running XOR parity bit: preset on clear, folds din in when en is high.
// Shared between the receive checker and the transmit parity generator.
module parity_accum (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic preset,
  input  logic en,
  input  logic din,
  output logic q
);

  logic acc_d, acc_q;

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = preset;
    end else if (en) begin
      acc_d = acc_q ^ din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign q = acc_q;

endmodule

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start, DATA_W bits LSB first, optional parity, stop.
// Parity checking is built only when PARITY_FRAME_RX_PARITY_EN is defined.
module parity_frame_rx
  import parity_frame_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter bit          ODD_PARITY = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  parity_frame_rx_if.slave bus
);

  localparam int unsigned         CntW    = cnt_width(DATA_W);
  localparam logic [CntW-1:0]     LastBit = CntW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              frame_err_q, frame_err_d;
  logic              busy_q;

`ifdef PARITY_FRAME_RX_PARITY_EN
  logic acc_clear, acc_en, acc;
  logic perr_flag_q, perr_flag_d;
  logic parity_err_q, parity_err_d;

  parity_accum u_accum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (acc_clear),
    .preset (ODD_PARITY),
    .en     (acc_en),
    .din    (bus.rx_in),
    .q      (acc)
  );
`else
  logic unused_odd_parity;
  assign unused_odd_parity = ODD_PARITY;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = frame_err_q;
`ifdef PARITY_FRAME_RX_PARITY_EN
    acc_clear    = 1'b0;
    acc_en       = 1'b0;
    perr_flag_d  = perr_flag_q;
    parity_err_d = parity_err_q;
`endif
    if (bus.bit_en) begin
      unique case (state_q)
        StIdle: begin
          if (bus.rx_in == StartLevel) begin
            state_d = StData;
            cnt_d   = '0;
            shift_d = '0;
`ifdef PARITY_FRAME_RX_PARITY_EN
            acc_clear = 1'b1;
`endif
          end
        end
        StData: begin
          shift_d = shift_q | (DATA_W'(bus.rx_in) << cnt_q);
          cnt_d   = cnt_q + 1'b1;
`ifdef PARITY_FRAME_RX_PARITY_EN
          acc_en = 1'b1;
          if (cnt_q == LastBit) state_d = StParity;
`else
          if (cnt_q == LastBit) state_d = StStop;
`endif
        end
`ifdef PARITY_FRAME_RX_PARITY_EN
        StParity: begin
          perr_flag_d = acc ^ bus.rx_in;
          state_d     = StStop;
        end
`endif
        StStop: begin
          // A low stop bit only flags the frame; IDLE still needs its own start strobe.
          frame_err_d = (bus.rx_in != IdleLevel);
          data_d      = shift_q;
          valid_d     = 1'b1;
          state_d     = StIdle;
`ifdef PARITY_FRAME_RX_PARITY_EN
          parity_err_d = perr_flag_q;
`endif
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= (state_d != StIdle);
    end
  end

`ifdef PARITY_FRAME_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_flag_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      perr_flag_q  <= perr_flag_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;

endmodule
